// File: rtl/scan_chain_ctrl_if.sv
// scan_chain_ctrl_if: host + scan-chain signal bundle for scan_chain_ctrl.
//   Host side : start, pattern_in, expect_val, mask -> controller
//               busy, done, pass, captured          <- controller
//   Chain side: scan_out                            -> controller
//               scan_mode, scan_in, scan_shift      <- controller
// expect_val carries the expected capture vector ("expect" is reserved in SV).
// slave  = the controller, master = host/bench driving it.
interface scan_chain_ctrl_if #(
  parameter int CHAIN_LEN = 7
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic [CHAIN_LEN-1:0] expect_val;
  logic [CHAIN_LEN-1:0] mask;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] captured;
  logic                 scan_out;
  logic                 scan_mode;
  logic                 scan_in;
  logic                 scan_shift;

  modport slave (
    input  start, pattern_in, expect_val, mask, scan_out,
    output busy, done, pass, captured, scan_mode, scan_in, scan_shift
  );

  modport master (
    output start, pattern_in, expect_val, mask, scan_out,
    input  busy, done, pass, captured, scan_mode, scan_in, scan_shift
  );
endinterface

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: runs one scan test pattern per start request.
//   LOAD    shifts the pattern in, MSB first, so bit i lands in cell i
//   SETTLE  SETTLE_CYC functional cycles (skipped when 0)
//   CAPTURE one functional capture pulse
//   UNLOAD  shifts the chain out into captured, cell CHAIN_LEN-1 first
//   COMPARE done pulse, pass = masked compare against expect_val
// Ports:
//   clk  clock (chain shares this edge, gated by scan_shift)
//   clr  asynchronous active-high reset
//   bus  scan_chain_ctrl_if.slave (host handshake + chain lines)
//   fail_cnt [7:0]  saturating count of failing runs, present only when
//                   SCAN_FAILCNT_EN is defined
// All outputs are registered.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN  = 7,
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic clr,
  scan_chain_ctrl_if.slave bus
`ifdef SCAN_FAILCNT_EN
  ,
  output logic [7:0] fail_cnt
`endif
);

  localparam int CW = $clog2(CHAIN_LEN + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, CAPTURE, UNLOAD, COMPARE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           scnt;
  logic [CHAIN_LEN-1:0] load_sr;   // remaining pattern bits, next bit at MSB
  logic [CHAIN_LEN-1:0] unl_sel;   // one-hot: captured bit written this unload cycle
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  logic [CHAIN_LEN-1:0] cap_nxt;
  logic                 cnt_last;
  logic                 pass_nxt;

  assign cnt_last = (cnt == CW'(CHAIN_LEN - 1));

  // captured with this cycle's scan_out merged in; on the final unload
  // cycle this is the complete vector, so pass is computed from it directly.
  always_comb begin
    cap_nxt  = bus.scan_out ? (bus.captured | unl_sel) : (bus.captured & ~unl_sel);
    pass_nxt = (((cap_nxt ^ exp_q) & mask_q) == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= IDLE;
      cnt            <= '0;
      scnt           <= '0;
      load_sr        <= '0;
      unl_sel        <= '0;
      exp_q          <= '0;
      mask_q         <= '0;
      bus.scan_mode  <= 1'b0;
      bus.scan_in    <= 1'b0;
      bus.scan_shift <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.captured   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done       <= 1'b0;
          bus.scan_mode  <= 1'b0;
          bus.scan_shift <= 1'b0;
          bus.scan_in    <= 1'b0;
          if (bus.start) begin
            exp_q          <= bus.expect_val;
            mask_q         <= bus.mask;
            bus.pass       <= 1'b0;
            bus.busy       <= 1'b1;
            // First load bit goes out now; the rest wait in load_sr.
            bus.scan_in    <= bus.pattern_in[CHAIN_LEN-1];
            load_sr        <= bus.pattern_in << 1;
            bus.scan_mode  <= 1'b1;
            bus.scan_shift <= 1'b1;
            cnt            <= '0;
            state          <= LOAD;
          end
        end
        LOAD: begin
          if (cnt_last) begin
            bus.scan_in   <= 1'b0;
            bus.scan_mode <= 1'b0;
            cnt           <= '0;
            scnt          <= '0;
            if (SETTLE_CYC == 0) begin
              bus.scan_shift <= 1'b1;
              state          <= CAPTURE;
            end else begin
              bus.scan_shift <= 1'b0;
              state          <= SETTLE;
            end
          end else begin
            bus.scan_in <= load_sr[CHAIN_LEN-1];
            load_sr     <= load_sr << 1;
            cnt         <= cnt + CW'(1);
          end
        end
        SETTLE: begin
          if (scnt == 4'(SETTLE_CYC - 1)) begin
            bus.scan_shift <= 1'b1;
            state          <= CAPTURE;
          end else begin
            scnt <= scnt + 4'd1;
          end
        end
        CAPTURE: begin
          bus.scan_mode  <= 1'b1;
          bus.scan_shift <= 1'b1;
          bus.scan_in    <= 1'b0;
          unl_sel        <= {1'b1, {(CHAIN_LEN-1){1'b0}}};
          cnt            <= '0;
          state          <= UNLOAD;
        end
        UNLOAD: begin
          bus.captured <= cap_nxt;
          unl_sel      <= unl_sel >> 1;
          if (cnt_last) begin
            bus.scan_mode  <= 1'b0;
            bus.scan_shift <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            bus.pass       <= pass_nxt;
            state          <= COMPARE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        COMPARE: begin
          // start is ignored here; it is accepted from the next IDLE cycle.
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCAN_FAILCNT_EN
  // Counts on the same edge that publishes pass, so it is current with done.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      fail_cnt <= 8'd0;
    else if (state == UNLOAD && cnt_last && !pass_nxt && fail_cnt != 8'hFF)
      fail_cnt <= fail_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (SETTLE_CYC 1 and 3) each with a
// behavioural 7-cell chain (ideal shift register; capture either holds or
// loads a chosen value). Expected results come from the run rules: captured
// is the loaded pattern (hold) or the capture value, pass is the masked
// compare, done lands 2*N+S+1 cycles after the accepting edge.
module tb_scan_chain_ctrl;
  localparam int N  = 7;
  localparam int S1 = 1;
  localparam int S3 = 3;
  localparam int D1 = 2*N + S1 + 1;
  localparam int D3 = 2*N + S3 + 1;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int fails1 = 0;
  int fails3 = 0;

  logic         start;
  logic [N-1:0] pat, ex, mk;
  logic         capm;
  logic [N-1:0] capv;
  logic [N-1:0] ch1 = '0;
  logic [N-1:0] ch3 = '0;

  scan_chain_ctrl_if #(.CHAIN_LEN(N)) b1 ();
  scan_chain_ctrl_if #(.CHAIN_LEN(N)) b3 ();

`ifdef SCAN_FAILCNT_EN
  logic [7:0] fc1, fc3;
`endif

  scan_chain_ctrl #(.CHAIN_LEN(N), .SETTLE_CYC(S1)) dut1 (
    .clk(clk), .clr(clr), .bus(b1.slave)
`ifdef SCAN_FAILCNT_EN
    , .fail_cnt(fc1)
`endif
  );

  scan_chain_ctrl #(.CHAIN_LEN(N), .SETTLE_CYC(S3)) dut3 (
    .clk(clk), .clr(clr), .bus(b3.slave)
`ifdef SCAN_FAILCNT_EN
    , .fail_cnt(fc3)
`endif
  );

  assign b1.start = start;  assign b3.start = start;
  assign b1.pattern_in = pat; assign b3.pattern_in = pat;
  assign b1.expect_val = ex;  assign b3.expect_val = ex;
  assign b1.mask = mk;        assign b3.mask = mk;

  // Chain models: cell 0 next to scan_in, cell N-1 drives scan_out.
  always @(posedge clk)
    if (b1.scan_shift)
      ch1 <= b1.scan_mode ? {ch1[N-2:0], b1.scan_in} : (capm ? capv : ch1);
  always @(posedge clk)
    if (b3.scan_shift)
      ch3 <= b3.scan_mode ? {ch3[N-2:0], b3.scan_in} : (capm ? capv : ch3);
  assign b1.scan_out = ch1[N-1];
  assign b3.scan_out = ch3[N-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run, observed on dut1 (u3=0) or dut3 (u3=1).
  task automatic run(input logic [N-1:0] p, e, m, input bit c_m,
                     input logic [N-1:0] c_v, input bit u3, input bit scramble);
    logic [N-1:0] exp_cap, seq, cap_obs;
    bit pexp, busy_ok, pass_obs, sm, ss, si, bz, dn;
    int d, mode0, nsh, dc;
    exp_cap = c_m ? c_v : p;
    pexp    = (((exp_cap ^ e) & m) == '0);
    d       = u3 ? D3 : D1;
    capm = c_m; capv = c_v; pat = p; ex = e; mk = m;
    start = 1'b1;
    dc = -1; mode0 = 0; nsh = 0; seq = '0; busy_ok = 1'b1;
    cap_obs = '0; pass_obs = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
      if (scramble) begin
        pat = N'($urandom); ex = N'($urandom); mk = N'($urandom);
      end
      sm = u3 ? b3.scan_mode  : b1.scan_mode;
      ss = u3 ? b3.scan_shift : b1.scan_shift;
      si = u3 ? b3.scan_in    : b1.scan_in;
      bz = u3 ? b3.busy       : b1.busy;
      dn = u3 ? b3.done       : b1.done;
      if (dn) begin
        dc = c;
        cap_obs  = u3 ? b3.captured : b1.captured;
        pass_obs = u3 ? b3.pass : b1.pass;
        break;
      end
      if (!bz) busy_ok = 1'b0;
      if (!sm) mode0++;
      if (ss && sm && nsh < N) begin
        seq[N-1-nsh] = si;
        nsh++;
      end
    end
    if (!pexp) begin fails1++; fails3++; end
    chk("done_cycle", dc, d);
    chk("captured", cap_obs, exp_cap);
    chk("pass", pass_obs, pexp);
    chk("func_cycles", mode0, (u3 ? S3 : S1) + 1);
    chk("load_seq", seq, p);
    chk("busy_between", busy_ok, 1'b1);
`ifdef SCAN_FAILCNT_EN
    chk("fail_cnt", u3 ? fc3 : fc1, u3 ? (fails3 > 255 ? 255 : fails3) : (fails1 > 255 ? 255 : fails1));
`endif
    @(negedge clk);
    chk("done_width", u3 ? b3.done : b1.done, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int q[$];
    int got[$];
    int acc;
    logic [N-1:0] r;
    clr = 1'b1; start = 1'b0; pat = '0; ex = '0; mk = '0; capm = 1'b0; capv = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs1", {b1.scan_mode, b1.scan_in, b1.scan_shift, b1.busy, b1.done, b1.pass, b1.captured}, 32'd0);
    chk("rst_outs3", {b3.scan_mode, b3.scan_in, b3.scan_shift, b3.busy, b3.done, b3.pass, b3.captured}, 32'd0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback runs
    run(7'b1011001, 7'b1011001, 7'h7F, 1'b0, '0, 1'b0, 1'b0);
    run(7'b1011001, 7'b1011000, 7'h7F, 1'b0, '0, 1'b0, 1'b0);
    run(7'b1011001, 7'b1011000, 7'h7E, 1'b0, '0, 1'b0, 1'b0);
    run(7'b1011001, 7'b1011001, 7'h7F, 1'b0, '0, 1'b1, 1'b0);
    // Capture model
    run(7'b1100010, 7'b0000111, 7'h7F, 1'b1, 7'b0000111, 1'b0, 1'b0);
    run(7'b1100010, 7'b0000111, 7'h7F, 1'b1, 7'b0000111, 1'b1, 1'b0);
    // Mask all zeros always passes
    run(7'b0101010, 7'b1010101, 7'h00, 1'b0, '0, 1'b0, 1'b0);

    // clr during LOAD cycle 3
    pat = 7'b1110001; ex = pat; mk = 7'h7F; capm = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    chk("busy_pre_clr", b1.busy, 1'b1);
    clr = 1'b1; #1;
    chk("clr_outs1", {b1.scan_mode, b1.scan_in, b1.scan_shift, b1.busy, b1.done, b1.pass, b1.captured}, 32'd0);
    chk("clr_outs3", {b3.scan_mode, b3.scan_in, b3.scan_shift, b3.busy, b3.done, b3.pass, b3.captured}, 32'd0);
`ifdef SCAN_FAILCNT_EN
    chk("clr_failcnt", fc1, 32'd0);
`endif
    fails1 = 0; fails3 = 0;
    @(negedge clk); clr = 1'b0;
    ch1 = '0; ch3 = '0;
    @(negedge clk);
    run(7'b0011101, 7'b0011101, 7'h7F, 1'b0, '0, 1'b0, 1'b0);

    // Randomized runs; inputs change every cycle after acceptance
    for (int i = 0; i < 12; i++) begin
      r = N'($urandom);
      run(r, ($urandom_range(0, 1) != 0) ? r : N'($urandom), N'($urandom),
          1'(($urandom_range(0, 2)) == 0), N'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    // start held high for 20 cycles: one run per IDLE visit on dut1
    pat = 7'b0110110; ex = pat; mk = 7'h7F; capm = 1'b0;
    acc = 0;
    while (acc <= 19) begin q.push_back(acc + D1); acc += D1 + 2; end
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 19) start = 1'b0;
      if (b1.done) got.push_back(c);
    end
    chk("held_runs", got.size(), q.size());
    for (int i = 0; i < q.size() && i < got.size(); i++)
      chk("held_done_cycle", got[i], q[i]);
    repeat (20) @(negedge clk);

`ifdef SCAN_FAILCNT_EN
    for (int i = 0; i < 260; i++) begin
      r = N'($urandom);
      run(r, ~r, 7'h7F, 1'b0, '0, 1'b0, 1'b0);
    end
    run(7'b0000001, 7'b0000001, 7'h7F, 1'b0, '0, 1'b0, 1'b0);
    chk("failcnt_sat", fc1, 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
